seq_alu: RTL and testbench

- Parametrised, handshaked successor to the team's 4-bit ALU.
- Generic WIDTH operands, 3-bit opcode, registered result with flags, and a multi-cycle unsigned shift-add multiplier.
- Valid/ready on both input and output, so the block can sit between a sequencer/FSM and a result consumer with backpressure.
- Processes one operation at a time; no overlap.

---
 rtl/seq_alu.sv | 202 ++++++++++++++++++++
 tb/tb_seq_alu.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with a registered result and a multi-cycle multiplier.
//
// Operations (op): 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL,
// 110 MUL, 111 CMP. MUL is an unsigned shift-add multiply that takes WIDTH
// cycles. Every other op takes a single cycle. Only one operation is in
// flight at a time.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operation request; it is accepted when in_valid && in_ready
//   in_ready   block is idle and can accept a request
//   a, b       operands (WIDTH bits), sampled only at the accept edge
//   op         3-bit opcode
//   out_valid  result, result_hi and flags are valid and held
//   out_ready  consumer takes the result
//   result     result (low half of the product for MUL)
//   result_hi  high half of the MUL product; 0 for all other ops
//   flags      {C,Z,N,V}
//
// Build option: define ALU_SAT_EN to saturate signed overflow on ADD/SUB.
// The default build wraps and has no saturation logic.

module seq_alu #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_MUL = 3'b110,
    OP_CMP = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  // Shift amounts at or above WIDTH clear the result.
  localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH'(WIDTH);

`ifdef ALU_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;

  // Single-cycle datapath.
  logic [WIDTH:0]     add_full;
  logic [WIDTH-1:0]   diff;
  logic               add_v;
  logic               sub_v;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic               alu_z;
  logic               alu_n;

  assign add_full = {1'b0, a} + {1'b0, b};
  assign diff     = a - b;
  // Signed overflow: the operand signs make overflow possible and the sign
  // of the wrapped result disagrees with a.
  assign add_v = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
  assign sub_v = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

  // NOTE: every output of this block is given a default first, so no path
  // can leave a value unassigned and infer a latch.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    unique case (op)
      OP_ADD: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = add_v;
      end
      OP_SUB: begin
        alu_res = diff;
        alu_c   = (a < b);
        alu_v   = sub_v;
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_SHL: alu_res = (b >= SHIFT_LIM) ? '0 : (a << b);
      OP_MUL: alu_res = '0;
      OP_CMP: begin
        alu_c = (a < b);
        alu_v = sub_v;
      end
      default: alu_res = '0;
    endcase
`ifdef ALU_SAT_EN
    // Overflow direction follows the sign of a for both ADD and SUB:
    // a non-negative a can only overflow upward.
    if ((op == OP_ADD || op == OP_SUB) && alu_v)
      alu_res = a[WIDTH-1] ? SAT_MIN : SAT_MAX;
`endif
  end

  // CMP reports equality and the sign of the difference while leaving result at 0.
  assign alu_z = (op == OP_CMP) ? (a == b) : (alu_res == '0);
  assign alu_n = (op == OP_CMP) ? diff[WIDTH-1] : alu_res[WIDTH-1];

  // One MSB-first shift-add step: after WIDTH steps acc holds a*b.
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   prod_hi;
  logic [WIDTH-1:0]   prod_lo;

  assign acc_next = (acc << 1)
                  + {{WIDTH{1'b0}}, (mplier[WIDTH-1] ? mcand : {WIDTH{1'b0}})};
  assign prod_hi  = acc_next[2*WIDTH-1:WIDTH];
  assign prod_lo  = acc_next[WIDTH-1:0];

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the multiplier working registers are reset as well. They are
      // a handful of flops, and resetting them keeps an aborted multiply
      // from leaving stale partial products around.
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      flags     <= '0;
      cnt       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            if (op == OP_MUL) begin
              mcand  <= a;
              mplier <= b;
              acc    <= '0;
              cnt    <= CNT_W'(WIDTH);
              state  <= BUSY;
            end else begin
              result    <= alu_res;
              result_hi <= '0;
              flags     <= {alu_c, alu_z, alu_n, alu_v};
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        BUSY: begin
          acc    <= acc_next;
          mplier <= mplier << 1;
          cnt    <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            result    <= prod_lo;
            result_hi <= prod_hi;
            flags     <= {(prod_hi != '0), (acc_next == '0), prod_hi[WIDTH-1], 1'b0};
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed self-checking bench for seq_alu (WIDTH=4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Expected values are hand-computed. The saturating variants are selected
// with ALU_SAT_EN, matching the RTL build.

module tb_seq_alu;

  localparam int W = 4;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] AND = 3'b010;
  localparam logic [2:0] OR  = 3'b011;
  localparam logic [2:0] XOR = 3'b100;
  localparam logic [2:0] SHL = 3'b101;
  localparam logic [2:0] MUL = 3'b110;
  localparam logic [2:0] CMP = 3'b111;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic [3:0]   flags;

  int errors = 0;
  int checks = 0;
  int lat;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [W-1:0] r,
                           input logic [W-1:0] rh, input logic [3:0] f);
    check({tag, ".result"},    32'(result),    32'(r));
    check({tag, ".result_hi"}, 32'(result_hi), 32'(rh));
    check({tag, ".flags"},     32'(flags),     32'(f));
  endtask

  // Waits (bounded) for in_ready, then presents one request for one edge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    check("issue_in_ready", 32'(in_ready), 32'd1);
    op       = o;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Counts edges after acceptance until out_valid (bounded).
  task automatic wait_valid(input int max, output int cyc);
    cyc = 0;
    while (!out_valid && cyc < max) begin
      step();
      cyc++;
    end
    check("wait_out_valid", 32'(out_valid), 32'd1);
  endtask

  // Single-cycle op with out_ready high: result one cycle after accept, then consumed.
  task automatic single(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] r, input logic [3:0] f);
    issue(o, x, y);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check_out(tag, r, '0, f);
    step();
    check({tag, ".consumed"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    op        = ADD;
    step();
    rst = 1'b0;

    // Reset state.
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check_out("rst", 4'b0000, 4'b0000, 4'b0000);

    // flags are {C,Z,N,V}
    single("add_4_3", ADD, 4'b0100, 4'b0011, 4'b0111, 4'b0000);
    check("add_4_3.in_ready", 32'(in_ready), 32'd1);
    single("sub_2_5", SUB, 4'b0010, 4'b0101, 4'b1101, 4'b1010);
    single("cmp_5_5", CMP, 4'b0101, 4'b0101, 4'b0000, 4'b0100);
    single("and",     AND, 4'b1100, 4'b1010, 4'b1000, 4'b0010);
    single("or_zero", OR,  4'b0000, 4'b0000, 4'b0000, 4'b0100);
    single("shl_3_2", SHL, 4'b0011, 4'b0010, 4'b1100, 4'b0010);
    single("shl_oob", SHL, 4'b0011, 4'b0100, 4'b0000, 4'b0100);

    // MUL 15*9 = 135 = 1000_0111; in_ready stays low while busy.
    issue(MUL, 4'b1111, 4'b1001);
    a = 4'b0000;
    b = 4'b0000;
    check("mul.busy_in_ready", 32'(in_ready), 32'd0);
    wait_valid(10, lat);
    check("mul.latency", 32'(lat), 32'(W));
    check("mul.in_ready_done", 32'(in_ready), 32'd0);
    check_out("mul_15_9", 4'b0111, 4'b1000, 4'b1010);
    step();
    check("mul.consumed", 32'(out_valid), 32'd0);

    // MUL by zero: full product zero.
    issue(MUL, 4'b0000, 4'b1111);
    wait_valid(10, lat);
    check_out("mul_zero", 4'b0000, 4'b0000, 4'b0100);
    step();

    // Backpressure: result held while out_ready is low; operand changes ignored.
    out_ready = 1'b0;
    issue(ADD, 4'b1000, 4'b0111);
    op = XOR;
    a  = 4'b0000;
    b  = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      check("bp.out_valid", 32'(out_valid), 32'd1);
      check("bp.in_ready", 32'(in_ready), 32'd0);
      check_out("bp_hold", 4'b1111, 4'b0000, 4'b0010);
      step();
    end
    out_ready = 1'b1;
    step();
    check("bp.release_in_ready", 32'(in_ready), 32'd1);
    check("bp.release_out_valid", 32'(out_valid), 32'd0);

    // Reset two cycles into a MUL aborts it.
    issue(MUL, 4'b1111, 4'b1111);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort.out_valid", 32'(out_valid), 32'd0);
    check("abort.in_ready", 32'(in_ready), 32'd1);
    check_out("abort", 4'b0000, 4'b0000, 4'b0000);
    for (int i = 0; i < 6; i++) step();
    check("abort.no_late_valid", 32'(out_valid), 32'd0);
    single("xor_after_abort", XOR, 4'b1111, 4'b1001, 4'b0110, 4'b0000);

    // Signed overflow boundaries.
`ifdef ALU_SAT_EN
    single("add_ovf", ADD, 4'b0100, 4'b0100, 4'b0111, 4'b0001);
    single("sub_ovf", SUB, 4'b1000, 4'b0001, 4'b1000, 4'b0011);
`else
    single("add_ovf", ADD, 4'b0100, 4'b0100, 4'b1000, 4'b0011);
    single("sub_ovf", SUB, 4'b1000, 4'b0001, 4'b0111, 4'b0001);
`endif
    single("add_carry", ADD, 4'b1111, 4'b1001, 4'b1000, 4'b1010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
